intersection_ctrl: RTL and testbench

Sequencer for the three-phase ray/triangle intersection datapath: accepts a stream of triangle jobs for one ray over a valid/ready handshake and drives the datapath's `sel1`/`sel2` phase selects. It samples the resulting det/u/v/t, applies the hit test, and tracks the nearest hit across the stream. It sits between the triangle fetch unit and the intersection datapath. The top level routes ray/vertex vectors straight to the datapath, so this block carries only control and scalar results.

---
 rtl/intersection_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_intersection_ctrl.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/intersection_ctrl.sv
// Control sequencer for the three-phase ray/triangle intersection datapath.
// Steps sel1/sel2 per job, samples det/u/v/t, and keeps the nearest hit for the ray.
module intersection_ctrl #(
    parameter int FIXED_W   = 32,
    parameter int FRAC_W    = 16,
    parameter int ID_W      = 16,
    parameter int PHASE_CYC = 2,
    parameter int EPS       = 1
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               tri_valid,
    output logic               tri_ready,
    input  logic [ID_W-1:0]    tri_id,
    input  logic               tri_last,
    output logic               sel1,
    output logic               sel2,
    input  logic [FIXED_W-1:0] dp_det,
    input  logic [FIXED_W-1:0] dp_u,
    input  logic [FIXED_W-1:0] dp_v,
    input  logic [FIXED_W-1:0] dp_t,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               res_hit,
    output logic [ID_W-1:0]    res_id,
    output logic [FIXED_W-1:0] res_t,
    output logic [FIXED_W-1:0] res_u,
    output logic [FIXED_W-1:0] res_v,
    output logic               busy
);

    localparam int CNT_W = (PHASE_CYC > 1) ? $clog2(PHASE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PHASE_CYC - 1);
    localparam logic signed [FIXED_W-1:0] T_MAX = {1'b0, {(FIXED_W-1){1'b1}}};
    localparam logic signed [FIXED_W-1:0] S_MIN = {1'b1, {(FIXED_W-1){1'b0}}};
    localparam logic signed [FIXED_W-1:0] EPS_V = FIXED_W'(EPS);
    localparam logic signed [FIXED_W:0]   ONE_V = {{(FIXED_W-FRAC_W){1'b0}}, 1'b1, {FRAC_W{1'b0}}};

    typedef enum logic [2:0] {IDLE, PH_U, PH_V, PH_T, EVAL, RESULT} state_e;

    typedef struct packed {
        logic               hit;
        logic [ID_W-1:0]    id;
        logic [FIXED_W-1:0] t;
        logic [FIXED_W-1:0] u;
        logic [FIXED_W-1:0] v;
    } best_rec_t;

    localparam best_rec_t BEST_RST = '{hit: 1'b0, id: '0, t: T_MAX, u: '0, v: '0};

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               last_q, last_d;
    logic [FIXED_W-1:0] det_q, det_d;
    logic [FIXED_W-1:0] u_q, u_d;
    logic [FIXED_W-1:0] v_q, v_d;
    best_rec_t          best_q, best_d;
    logic               tri_ready_q, tri_ready_d;
    logic               sel1_q, sel1_d;
    logic               sel2_q, sel2_d;
    logic               res_valid_q, res_valid_d;
    logic               busy_q, busy_d;

    logic signed [FIXED_W-1:0] det_s, u_s, v_s, t_s, best_t_s, det_abs;
    logic signed [FIXED_W:0]   uv_sum;
    logic                      hit_w, cnt_last, cnt_first;

    assign det_s    = det_q;
    assign u_s      = u_q;
    assign v_s      = v_q;
    assign t_s      = dp_t;
    assign best_t_s = best_q.t;

    // One extra bit keeps u+v from wrapping before the ONE comparison.
    assign uv_sum = {u_s[FIXED_W-1], u_s} + {v_s[FIXED_W-1], v_s};

    always_comb begin
        if (det_s == S_MIN)   det_abs = T_MAX;
        else if (det_s < 0)   det_abs = -det_s;
        else                  det_abs = det_s;
    end

    // Strict less-than on t: an equal later hit never displaces the stored one.
    assign hit_w = (det_abs >= EPS_V) && !u_s[FIXED_W-1] && !v_s[FIXED_W-1] &&
                   (uv_sum <= ONE_V) && (t_s >= EPS_V) && (t_s < best_t_s);

    assign cnt_last  = (cnt_q == '0);
    assign cnt_first = (cnt_q == CNT_LOAD);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        id_d    = id_q;
        last_d  = last_q;
        det_d   = det_q;
        u_d     = u_q;
        v_d     = v_q;
        best_d  = best_q;
        case (state_q)
            IDLE: begin
                if (tri_valid && tri_ready_q) begin
                    id_d    = tri_id;
                    last_d  = tri_last;
                    cnt_d   = CNT_LOAD;
                    state_d = PH_U;
                end
            end
            PH_U: begin
                if (cnt_last) begin
                    det_d   = dp_det;
                    cnt_d   = CNT_LOAD;
                    state_d = PH_V;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            PH_V: begin
                if (cnt_first) u_d = dp_u;
                if (cnt_last) begin
                    cnt_d   = CNT_LOAD;
                    state_d = PH_T;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            PH_T: begin
                if (cnt_first) v_d = dp_v;
                if (cnt_last) state_d = EVAL;
                else          cnt_d   = cnt_q - CNT_W'(1);
            end
            EVAL: begin
                if (hit_w) best_d = '{hit: 1'b1, id: id_q, t: dp_t, u: u_q, v: v_q};
                state_d = last_q ? RESULT : IDLE;
            end
            RESULT: begin
                if (res_ready) begin
                    best_d  = BEST_RST;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they switch only on state-entry edges.
    always_comb begin
        tri_ready_d = (state_d == IDLE);
        sel1_d      = (state_d == PH_V) || (state_d == PH_T);
        sel2_d      = (state_d == PH_T);
        res_valid_d = (state_d == RESULT);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            id_q        <= '0;
            last_q      <= 1'b0;
            det_q       <= '0;
            u_q         <= '0;
            v_q         <= '0;
            best_q      <= BEST_RST;
            tri_ready_q <= 1'b0;
            sel1_q      <= 1'b0;
            sel2_q      <= 1'b0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            id_q        <= id_d;
            last_q      <= last_d;
            det_q       <= det_d;
            u_q         <= u_d;
            v_q         <= v_d;
            best_q      <= best_d;
            tri_ready_q <= tri_ready_d;
            sel1_q      <= sel1_d;
            sel2_q      <= sel2_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign tri_ready = tri_ready_q;
    assign sel1      = sel1_q;
    assign sel2      = sel2_q;
    assign res_valid = res_valid_q;
    assign busy      = busy_q;
    assign res_hit   = best_q.hit;
    assign res_id    = best_q.id;
    assign res_t     = best_q.t;
    assign res_u     = best_q.u;
    assign res_v     = best_q.v;

endmodule

// File: tb/tb_intersection_ctrl.sv
// Scoreboard bench for intersection_ctrl: directed rays at PHASE_CYC=2 plus a PHASE_CYC=1 throughput instance.
module tb_intersection_ctrl;

    localparam logic [31:0] T_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] BAD   = 32'hDEAD_0000;

    typedef struct packed {
        logic        hit;
        logic [15:0] id;
        logic [31:0] t;
        logic [31:0] u;
        logic [31:0] v;
    } res_s;

    typedef struct packed {
        logic [31:0] d;
        logic [31:0] u;
        logic [31:0] v;
        logic [31:0] t;
        logic        hit;
    } vec_s;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;
    int last_acc = 0;
    int acc1 [3];

    res_s exp_q [$];
    res_s exp_q1 [$];

    // instance 0 (PHASE_CYC = 2)
    logic        tri_valid, tri_ready, tri_last, sel1, sel2;
    logic [15:0] tri_id, res_id;
    logic [31:0] dp_det, dp_u, dp_v, dp_t, res_t, res_u, res_v;
    logic        res_valid, res_ready, res_hit, busy;
    logic [31:0] j_det, j_u, j_v, j_t;

    // Datapath stand-in: each value is only meaningful in its own phase.
    assign dp_det = j_det;
    assign dp_u   = (sel1 && !sel2) ? j_u : BAD;
    assign dp_v   = (sel1 && sel2) ? j_v : BAD;
    assign dp_t   = (!sel1 && !sel2) ? j_t : 32'h0;

    intersection_ctrl #(.PHASE_CYC(2)) u_dut0 (
        .clock(clock), .reset_n(reset_n),
        .tri_valid(tri_valid), .tri_ready(tri_ready), .tri_id(tri_id), .tri_last(tri_last),
        .sel1(sel1), .sel2(sel2),
        .dp_det(dp_det), .dp_u(dp_u), .dp_v(dp_v), .dp_t(dp_t),
        .res_valid(res_valid), .res_ready(res_ready), .res_hit(res_hit), .res_id(res_id),
        .res_t(res_t), .res_u(res_u), .res_v(res_v), .busy(busy)
    );

    // instance 1 (PHASE_CYC = 1)
    logic        tri_valid_1, tri_ready_1, tri_last_1, sel1_1, sel2_1;
    logic [15:0] tri_id_1, res_id_1;
    logic [31:0] res_t_1, res_u_1, res_v_1;
    logic        res_valid_1, res_ready_1, res_hit_1, busy_1;

    intersection_ctrl #(.PHASE_CYC(1)) u_dut1 (
        .clock(clock), .reset_n(reset_n),
        .tri_valid(tri_valid_1), .tri_ready(tri_ready_1), .tri_id(tri_id_1), .tri_last(tri_last_1),
        .sel1(sel1_1), .sel2(sel2_1),
        .dp_det(32'h0001_0000), .dp_u(32'h0000_1000), .dp_v(32'h0000_1000), .dp_t(32'h0004_0000),
        .res_valid(res_valid_1), .res_ready(res_ready_1), .res_hit(res_hit_1), .res_id(res_id_1),
        .res_t(res_t_1), .res_u(res_u_1), .res_v(res_v_1), .busy(busy_1)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [15:0] id, input logic last,
                         input logic [31:0] d, input logic [31:0] u,
                         input logic [31:0] v, input logic [31:0] t);
        int n = 0;
        @(negedge clock);
        tri_valid = 1'b1;
        tri_id    = id;
        tri_last  = last;
        while (!tri_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!tri_ready) begin
            chk("accept_timeout", 128'(tri_ready), 128'(1));
            tri_valid = 1'b0;
        end else begin
            @(posedge clock);
            #1;
            last_acc  = cyc;
            tri_valid = 1'b0;
            j_det = d; j_u = u; j_v = v; j_t = t;
        end
    endtask

    task automatic drain0();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk("drain0", 128'(exp_q.size()), 128'(0));
    endtask

    // Monitor for instance 0: latency on rising res_valid, values on handshake.
    initial begin
        logic prev_rv = 1'b0;
        res_s e;
        forever begin
            @(negedge clock);
            if (res_valid && !prev_rv) chk("latency", 128'(cyc - last_acc), 128'(7));
            prev_rv = res_valid;
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 128'(0), 128'(1));
                end else begin
                    e = exp_q.pop_front();
                    chk("result", 128'({res_hit, res_id, res_t, res_u, res_v}), 128'(e));
                end
            end
        end
    end

    // Monitor for instance 1.
    initial begin
        res_s e;
        forever begin
            @(negedge clock);
            if (res_valid_1 && res_ready_1) begin
                if (exp_q1.size() == 0) begin
                    chk("unexpected_result1", 128'(0), 128'(1));
                end else begin
                    e = exp_q1.pop_front();
                    chk("result1", 128'({res_hit_1, res_id_1, res_t_1, res_u_1, res_v_1}), 128'(e));
                    chk("latency1", 128'(cyc - acc1[2]), 128'(4));
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [1:0] sel_exp [7] = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b11, 2'b11, 2'b00};

    vec_s rej [8] = '{
        '{32'h0000_0000, 32'h0000_4000, 32'h0000_4000, 32'h0001_0000, 1'b0},  // det = 0
        '{32'h0001_0000, 32'hFFFF_0000, 32'h0000_4000, 32'h0001_0000, 1'b0},  // u < 0
        '{32'h0001_0000, 32'h0000_8001, 32'h0000_8001, 32'h0001_0000, 1'b0},  // u+v > ONE
        '{32'h0001_0000, 32'h0000_4000, 32'h0000_4000, 32'h0000_0000, 1'b0},  // t = 0
        '{32'h0001_0000, 32'h0000_8000, 32'h0000_8000, 32'h0001_0000, 1'b1},  // u+v = ONE
        '{32'h8000_0000, 32'h0000_1000, 32'h0000_1000, 32'h0002_0000, 1'b1},  // det = min
        '{32'hFFFF_0000, 32'h0000_1000, 32'h0000_2000, 32'h0003_0000, 1'b1},  // det < 0
        '{32'h0001_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0001, 1'b1}   // t = EPS
    };

    initial begin
        res_s e;
        int n;
        int n_acc;
        tri_valid = 0; tri_id = 0; tri_last = 0; res_ready = 1;
        j_det = 0; j_u = 0; j_v = 0; j_t = 0;
        tri_valid_1 = 0; tri_id_1 = 0; tri_last_1 = 0; res_ready_1 = 1;

        #12;
        chk("reset_ctrl", 128'({tri_ready, sel1, sel2, res_valid, res_hit, busy}), 128'(0));
        chk("reset_res", 128'({res_id, res_t, res_u, res_v}), 128'({16'h0, T_MAX, 32'h0, 32'h0}));
        @(negedge clock);
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("ready_after_reset", 128'(tri_ready), 128'(1));

        // single hit with phase-select sequence
        exp_q.push_back('{1'b1, 16'h0007, 32'h0005_0000, 32'h0000_4000, 32'h0000_4000});
        issue(16'h0007, 1'b1, 32'h0001_0000, 32'h0000_4000, 32'h0000_4000, 32'h0005_0000);
        for (int k = 0; k < 7; k++) begin
            @(negedge clock);
            chk($sformatf("sel_%0d", k), 128'({sel1, sel2}), 128'(sel_exp[k]));
        end
        drain0();

        // nearest of three, tie at t=2.0 keeps id 2
        exp_q.push_back('{1'b1, 16'h0002, 32'h0002_0000, 32'h0000_2000, 32'h0000_3000});
        issue(16'h0001, 1'b0, 32'h0001_0000, 32'h0000_1000, 32'h0000_1000, 32'h0005_0000);
        issue(16'h0002, 1'b0, 32'h0001_0000, 32'h0000_2000, 32'h0000_3000, 32'h0002_0000);
        issue(16'h0003, 1'b1, 32'h0001_0000, 32'h0000_3000, 32'h0000_1000, 32'h0002_0000);
        drain0();

        // single-triangle rays around the hit-test boundaries
        for (int i = 0; i < 8; i++) begin
            if (rej[i].hit) exp_q.push_back('{1'b1, 16'(16'h0100 + i), rej[i].t, rej[i].u, rej[i].v});
            else            exp_q.push_back('{1'b0, 16'h0, T_MAX, 32'h0, 32'h0});
            issue(16'(16'h0100 + i), 1'b1, rej[i].d, rej[i].u, rej[i].v, rej[i].t);
            drain0();
        end

        // back-pressure on the result
        @(posedge clock);
        #1;
        res_ready = 1'b0;
        e = '{1'b1, 16'h0055, 32'h0003_0000, 32'h0000_0100, 32'h0000_0200};
        exp_q.push_back(e);
        issue(16'h0055, 1'b1, 32'h0001_0000, 32'h0000_0100, 32'h0000_0200, 32'h0003_0000);
        n = 0;
        while (!res_valid && n < 50) begin
            @(negedge clock);
            n++;
        end
        chk("bp_valid", 128'(res_valid), 128'(1));
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            chk($sformatf("bp_hold_%0d", k),
                128'({tri_ready, res_valid, res_hit, res_id, res_t, res_u, res_v}),
                128'({1'b0, 1'b1, e}));
        end
        @(posedge clock);
        #1;
        res_ready = 1'b1;
        @(posedge clock);
        #1;
        chk("bp_release", 128'({tri_ready, res_valid, busy}), 128'(3'b100));
        chk("bp_cleared", 128'({res_hit, res_id, res_t, res_u, res_v}), 128'({1'b0, 16'h0, T_MAX, 64'h0}));
        exp_q.push_back('{1'b0, 16'h0, T_MAX, 32'h0, 32'h0});
        issue(16'h0056, 1'b1, 32'h0000_0000, 32'h0000_0100, 32'h0000_0200, 32'h0003_0000);
        drain0();

        // reset in the middle of PH_V, after a hit was already recorded
        issue(16'h0021, 1'b0, 32'h0001_0000, 32'h0000_1000, 32'h0000_1000, 32'h0001_0000);
        issue(16'h0022, 1'b1, 32'h0001_0000, 32'h0000_1000, 32'h0000_1000, 32'h0000_8000);
        @(posedge clock);
        @(posedge clock);
        #1;
        chk("in_ph_v", 128'({sel1, sel2, busy}), 128'(3'b101));
        reset_n = 1'b0;
        #1;
        chk("reset_mid", 128'({sel1, sel2, busy, tri_ready, res_valid}), 128'(0));
        @(negedge clock);
        reset_n = 1'b1;
        exp_q.push_back('{1'b0, 16'h0, T_MAX, 32'h0, 32'h0});
        issue(16'h0023, 1'b1, 32'h0000_0000, 32'h0000_1000, 32'h0000_1000, 32'h0001_0000);
        drain0();

        // PHASE_CYC=1: back-to-back jobs, equal t, first one wins
        exp_q1.push_back('{1'b1, 16'h0001, 32'h0004_0000, 32'h0000_1000, 32'h0000_1000});
        @(negedge clock);
        tri_valid_1 = 1'b1;
        tri_id_1    = 16'h0001;
        tri_last_1  = 1'b0;
        n_acc = 0;
        n = 0;
        while (n_acc < 3 && n < 100) begin
            @(negedge clock);
            n++;
            if (tri_ready_1) begin
                @(posedge clock);
                #1;
                acc1[n_acc] = cyc;
                n_acc++;
                tri_id_1   = 16'(n_acc + 1);
                tri_last_1 = (n_acc == 2);
                if (n_acc == 3) tri_valid_1 = 1'b0;
            end
        end
        chk("p1_accepts", 128'(n_acc), 128'(3));
        chk("p1_gap_a", 128'(acc1[1] - acc1[0]), 128'(5));
        chk("p1_gap_b", 128'(acc1[2] - acc1[1]), 128'(5));
        n = 0;
        while (exp_q1.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("drain1", 128'(exp_q1.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
